// File: rtl/cva6_cheri_pkg.sv
// Shared CHERI types for the branch-resolve path: capability PCC, resolved-branch record,
// and the helper that strips a capability down to a plain address for legacy mode.
package cva6_cheri_pkg;

    localparam int unsigned BRQ_DEFAULT_DEPTH = 4;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        logic        tag;
        logic [11:0] perms;
        logic [3:0]  otype;
        logic [27:0] bounds;
        logic [63:0] addr;
    } cap_pcc_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        cap_pcc_t    target_address;
        logic        is_mispredict;
        logic        is_taken;
        cf_t         cf_type;
    } bp_resolve_t;

    // Keep only the address so a legacy target can never look like a tagged capability.
    function automatic cap_pcc_t sanitize_cap_pcc_legacy(cap_pcc_t cap);
        cap_pcc_t mask;
        mask      = '0;
        mask.addr = '1;
        return cap & mask;
    endfunction

endpackage

// File: rtl/brq_compact.sv
// Compaction network for the resolve queue: each valid port gets the slot offset equal
// to the number of valid ports below it, so accepted records pack without gaps.
module brq_compact #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned OW       = $clog2(NR_PORTS + 1)
) (
    input  logic [NR_PORTS-1:0] i_valid,
    input  logic                i_en,
    output logic [NR_PORTS-1:0] o_we,
    output logic [OW-1:0]       o_offset [NR_PORTS],
    output logic [OW-1:0]       o_cnt
);

    logic [OW-1:0] w_prefixSum;

    always_comb begin
        w_prefixSum = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            o_offset[i] = w_prefixSum;
            w_prefixSum = w_prefixSum + OW'(i_valid[i]);
        end
        o_cnt = i_en ? w_prefixSum : '0;
        o_we  = i_valid & {NR_PORTS{i_en}};
    end

endmodule

// File: rtl/cheri_branch_resolve_queue.sv
// In-order queue of resolved CHERI branch records: accepts up to NR_PORTS compacted
// records per cycle and hands one per cycle to the frontend over valid/ready.
module cheri_branch_resolve_queue
    import cva6_cheri_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = BRQ_DEFAULT_DEPTH,
    parameter bit          CAP_MODE = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  bp_resolve_t                  resolved_branch_i [NR_PORTS],
    output logic                         in_ready_o,
    output bp_resolve_t                  resolved_branch_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         mispredict_pending_o,
    output logic                         tag_fault_o,
    output logic                         overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(NR_PORTS + 1);

    bp_resolve_t       r_mem [DEPTH];
    logic [DEPTH-1:0]  r_entryValid;
    logic [PW-1:0]     r_rdPtr;
    logic [PW-1:0]     r_wrPtr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic [NR_PORTS-1:0] w_portValid;
    logic [NR_PORTS-1:0] w_we;
    logic [OW-1:0]       w_offset [NR_PORTS];
    logic [OW-1:0]       w_pushCnt;
    logic [PW-1:0]       w_wrIdx [NR_PORTS];
    bp_resolve_t         w_wrData [NR_PORTS];
    logic                w_inReady;
    logic                w_outValid;
    logic                w_pop;
    logic                w_drop;
    logic [DEPTH-1:0]    w_entryValidNext;
    logic                w_mispAny;
    bp_resolve_t         w_head;

    // Space is judged on the registered count alone, so a same-cycle pop never helps a push.
    assign w_inReady  = (r_count <= CW'(DEPTH - NR_PORTS));
    assign w_outValid = (r_count != '0);
    assign w_pop      = w_outValid & out_ready_i;
    assign w_drop     = (|w_portValid) & ~w_inReady;

    always_comb begin
        for (int i = 0; i < NR_PORTS; i++) begin
            w_portValid[i] = resolved_branch_i[i].valid;
            w_wrData[i]    = resolved_branch_i[i];
            if (!CAP_MODE) begin
                w_wrData[i].target_address = sanitize_cap_pcc_legacy(resolved_branch_i[i].target_address);
            end
            w_wrIdx[i] = r_wrPtr + PW'(w_offset[i]);
        end
    end

    brq_compact #(
        .NR_PORTS (NR_PORTS),
        .OW       (OW)
    ) u_compact (
        .i_valid  (w_portValid),
        .i_en     (w_inReady & ~flush_i & ~rst_i),
        .o_we     (w_we),
        .o_offset (w_offset),
        .o_cnt    (w_pushCnt)
    );

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_PORTS; i++) begin
            if (w_we[i]) begin
                r_mem[w_wrIdx[i]] <= w_wrData[i];
            end
        end
    end

    // Writes only ever land in free slots, so clearing the popped slot cannot collide.
    always_comb begin
        w_entryValidNext = r_entryValid;
        if (w_pop) begin
            w_entryValidNext[r_rdPtr] = 1'b0;
        end
        for (int i = 0; i < NR_PORTS; i++) begin
            if (w_we[i]) begin
                w_entryValidNext[w_wrIdx[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count      <= '0;
            r_rdPtr      <= '0;
            r_wrPtr      <= '0;
            r_entryValid <= '0;
            r_overflow   <= 1'b0;
        end else if (flush_i) begin
            r_count      <= '0;
            r_rdPtr      <= '0;
            r_wrPtr      <= '0;
            r_entryValid <= '0;
        end else begin
            r_count      <= r_count + CW'(w_pushCnt) - CW'(w_pop);
            r_rdPtr      <= r_rdPtr + PW'(w_pop);
            r_wrPtr      <= r_wrPtr + PW'(w_pushCnt);
            r_entryValid <= w_entryValidNext;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_mispAny = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_mispAny = w_mispAny | (r_entryValid[i] & r_mem[i].is_mispredict);
        end
    end

    // Head is gated to zero when empty so reset leaves a clean, all-zero output record.
    always_comb begin
        w_head                  = r_mem[r_rdPtr];
        resolved_branch_o       = w_outValid ? w_head : '0;
        resolved_branch_o.valid = w_outValid;
    end

    assign tag_fault_o          = CAP_MODE ? (w_outValid & w_head.is_taken & ~w_head.target_address.tag) : 1'b0;
    assign in_ready_o           = w_inReady;
    assign out_valid_o          = w_outValid;
    assign count_o              = r_count;
    assign mispredict_pending_o = w_mispAny;
    assign overflow_o           = r_overflow;

endmodule

// File: tb/tb_cheri_branch_resolve_queue.sv
// Directed bench for the branch resolve queue: a capability-mode instance exercises
// ordering, overflow, wrap, flush and tag faults; a legacy instance checks sanitising.
module tb_cheri_branch_resolve_queue;
    import cva6_cheri_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        out_ready_i;
    bp_resolve_t brIn [2];
    bp_resolve_t headOut;
    logic        inReady;
    logic        outValid;
    logic [2:0]  count;
    logic        mispPending;
    logic        tagFault;
    logic        overflow;

    bp_resolve_t brInB [2];
    logic        outReadyB;
    bp_resolve_t headOutB;
    logic        inReadyB;
    logic        outValidB;
    logic [2:0]  countB;
    logic        mispPendingB;
    logic        tagFaultB;
    logic        overflowB;

    int testCount = 0;
    int failCount = 0;

    bp_resolve_t none;
    cap_pcc_t    expCap;

    always #5 clk_i = ~clk_i;

    cheri_branch_resolve_queue #(.NR_PORTS(2), .DEPTH(4), .CAP_MODE(1'b1)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .flush_i              (flush_i),
        .resolved_branch_i    (brIn),
        .in_ready_o           (inReady),
        .resolved_branch_o    (headOut),
        .out_valid_o          (outValid),
        .out_ready_i          (out_ready_i),
        .count_o              (count),
        .mispredict_pending_o (mispPending),
        .tag_fault_o          (tagFault),
        .overflow_o           (overflow)
    );

    cheri_branch_resolve_queue #(.NR_PORTS(2), .DEPTH(4), .CAP_MODE(1'b0)) dutLegacy (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .flush_i              (flush_i),
        .resolved_branch_i    (brInB),
        .in_ready_o           (inReadyB),
        .resolved_branch_o    (headOutB),
        .out_valid_o          (outValidB),
        .out_ready_i          (outReadyB),
        .count_o              (countB),
        .mispredict_pending_o (mispPendingB),
        .tag_fault_o          (tagFaultB),
        .overflow_o           (overflowB)
    );

    function automatic bp_resolve_t mkRec(logic [63:0] pc, logic taken, logic misp,
                                          logic tag, logic [63:0] addr);
        bp_resolve_t r;
        r                       = '0;
        r.valid                 = 1'b1;
        r.pc                    = pc;
        r.is_taken              = taken;
        r.is_mispredict         = misp;
        r.cf_type               = Branch;
        r.target_address.tag    = tag;
        r.target_address.perms  = 12'hABC;
        r.target_address.otype  = 4'h5;
        r.target_address.bounds = 28'h1234567;
        r.target_address.addr   = addr;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the main instance, then return to idle just after the edge.
    task automatic applyStimulus(input bp_resolve_t r0, input bp_resolve_t r1, input logic fl, input logic rdy);
        brIn[0]     = r0;
        brIn[1]     = r1;
        flush_i     = fl;
        out_ready_i = rdy;
        @(posedge clk_i);
        #1;
        brIn[0]     = '0;
        brIn[1]     = '0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
    endtask

    initial begin
        none        = '0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        outReadyB   = 1'b0;
        brIn[0]     = '0;
        brIn[1]     = '0;
        brInB[0]    = '0;
        brInB[1]    = '0;

        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkOutput("rst_count", 256'(count), 256'(0));
        checkOutput("rst_out_valid", 256'(outValid), 256'(0));
        checkOutput("rst_in_ready", 256'(inReady), 256'(1));
        checkOutput("rst_overflow", 256'(overflow), 256'(0));
        checkOutput("rst_head_zero", 256'(headOut), 256'(0));
        checkOutput("rst_misp", 256'(mispPending), 256'(0));
        checkOutput("rst_tag_fault", 256'(tagFault), 256'(0));
        checkOutput("rst_legacy_count", 256'(countB), 256'(0));

        applyStimulus(none, mkRec(64'h8000_0010, 1'b0, 1'b0, 1'b1, 64'h0), 1'b0, 1'b0);
        checkOutput("cmp_count1", 256'(count), 256'(1));
        checkOutput("cmp_valid1", 256'(outValid), 256'(1));
        checkOutput("cmp_head_10", 256'(headOut.pc), 256'(64'h8000_0010));
        applyStimulus(mkRec(64'h8000_0020, 1'b0, 1'b0, 1'b1, 64'h0),
                      mkRec(64'h8000_0030, 1'b0, 1'b0, 1'b1, 64'h0), 1'b0, 1'b0);
        checkOutput("cmp_count3", 256'(count), 256'(3));
        checkOutput("cmp_head_still_10", 256'(headOut.pc), 256'(64'h8000_0010));
        applyStimulus(none, none, 1'b0, 1'b1);
        checkOutput("cmp_count2", 256'(count), 256'(2));
        checkOutput("cmp_head_20", 256'(headOut.pc), 256'(64'h8000_0020));
        applyStimulus(none, none, 1'b0, 1'b1);
        checkOutput("cmp_count1b", 256'(count), 256'(1));
        checkOutput("cmp_head_30", 256'(headOut.pc), 256'(64'h8000_0030));
        applyStimulus(none, none, 1'b0, 1'b1);
        checkOutput("cmp_count0", 256'(count), 256'(0));
        checkOutput("cmp_empty", 256'(outValid), 256'(0));

        applyStimulus(mkRec(64'h100, 1'b0, 1'b0, 1'b1, 64'h0), mkRec(64'h104, 1'b0, 1'b0, 1'b1, 64'h0), 1'b0, 1'b0);
        checkOutput("full_count2_ready", 256'(inReady), 256'(1));
        applyStimulus(mkRec(64'h108, 1'b0, 1'b0, 1'b1, 64'h0), none, 1'b0, 1'b0);
        checkOutput("full_count3", 256'(count), 256'(3));
        checkOutput("full_not_ready", 256'(inReady), 256'(0));
        checkOutput("full_no_ovf_yet", 256'(overflow), 256'(0));
        applyStimulus(mkRec(64'h40, 1'b0, 1'b0, 1'b1, 64'h0), none, 1'b0, 1'b0);
        checkOutput("ovf_count_kept", 256'(count), 256'(3));
        checkOutput("ovf_set", 256'(overflow), 256'(1));
        applyStimulus(none, none, 1'b0, 1'b1);
        checkOutput("ovf_pop_count", 256'(count), 256'(2));
        checkOutput("ovf_pop_ready", 256'(inReady), 256'(1));
        checkOutput("ovf_pop_head", 256'(headOut.pc), 256'(64'h104));
        applyStimulus(none, none, 1'b1, 1'b0);
        checkOutput("ovf_flush_count", 256'(count), 256'(0));
        checkOutput("ovf_sticky", 256'(overflow), 256'(1));

        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkOutput("rst2_overflow", 256'(overflow), 256'(0));
        applyStimulus(mkRec(64'h1000, 1'b0, 1'b0, 1'b1, 64'h0), none, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            checkOutput("wrap_head", 256'(headOut.pc), 256'(64'h1000 + 64'(4 * k)));
            applyStimulus(mkRec(64'h1000 + 64'(4 * (k + 1)), 1'b0, 1'b0, 1'b1, 64'h0), none, 1'b0, 1'b1);
            checkOutput("wrap_count", 256'(count), 256'(1));
        end
        checkOutput("wrap_last_head", 256'(headOut.pc), 256'(64'h1028));
        checkOutput("wrap_no_ovf", 256'(overflow), 256'(0));
        applyStimulus(none, none, 1'b0, 1'b1);
        checkOutput("wrap_drain", 256'(count), 256'(0));

        applyStimulus(mkRec(64'h2000, 1'b1, 1'b1, 1'b1, 64'h0), mkRec(64'h2004, 1'b0, 1'b0, 1'b1, 64'h0), 1'b0, 1'b0);
        checkOutput("fl_count2", 256'(count), 256'(2));
        checkOutput("fl_misp_set", 256'(mispPending), 256'(1));
        applyStimulus(mkRec(64'h3000, 1'b0, 1'b0, 1'b1, 64'h0), mkRec(64'h3004, 1'b0, 1'b0, 1'b1, 64'h0), 1'b1, 1'b1);
        checkOutput("fl_count0", 256'(count), 256'(0));
        checkOutput("fl_out_valid", 256'(outValid), 256'(0));
        checkOutput("fl_misp_clr", 256'(mispPending), 256'(0));
        checkOutput("fl_ovf_kept", 256'(overflow), 256'(0));

        applyStimulus(mkRec(64'h4000, 1'b1, 1'b0, 1'b0, 64'h5000), mkRec(64'h4004, 1'b1, 1'b0, 1'b1, 64'h6000), 1'b0, 1'b0);
        checkOutput("cap_fault_tag0", 256'(tagFault), 256'(1));
        checkOutput("cap_target_kept", 256'(headOut.target_address),
                    256'(mkRec(64'h0, 1'b0, 1'b0, 1'b0, 64'h5000).target_address));
        applyStimulus(none, none, 1'b0, 1'b1);
        checkOutput("cap_no_fault_tag1", 256'(tagFault), 256'(0));
        checkOutput("cap_head_4004", 256'(headOut.pc), 256'(64'h4004));
        applyStimulus(none, none, 1'b0, 1'b1);
        applyStimulus(mkRec(64'h4008, 1'b0, 1'b0, 1'b0, 64'h7000), none, 1'b0, 1'b0);
        checkOutput("cap_untaken_no_fault", 256'(tagFault), 256'(0));

        brInB[0] = mkRec(64'h6000, 1'b1, 1'b0, 1'b1, 64'h1234);
        @(posedge clk_i);
        #1;
        brInB[0]    = '0;
        expCap      = '0;
        expCap.addr = 64'h1234;
        checkOutput("leg_count", 256'(countB), 256'(1));
        checkOutput("leg_target", 256'(headOutB.target_address), 256'(expCap));
        checkOutput("leg_tag_fault", 256'(tagFaultB), 256'(0));
        checkOutput("leg_pc", 256'(headOutB.pc), 256'(64'h6000));
        checkOutput("leg_taken", 256'(headOutB.is_taken), 256'(1));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
